// File: rtl/rv_pkg.sv
// Shared definitions for the R-type instruction sequencer: opcodes,
// instruction field positions and the sequencer state encoding.
package rv_pkg;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/instr_buf.sv
// Program buffer: simple dual-port DEPTH x WIDTH RAM, one write port and one
// read port whose data appears the cycle after rd_en_i.
module instr_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: buffers a loaded program, then fetches, decodes and
// issues R-type instructions to the ALU until a halt word or the program end.
module instr_seq_ctrl
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [2:0]               funct3,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [6:0]               funct7,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW:0]      wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] rd_data_s;
  logic             last_s;
  logic             load_ready_s;
  logic             wr_en_s;

  instr_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_cnt_q[AW-1:0]),
    .wr_data_i (load_data),
    .rd_en_i   (state_q == ST_FETCH),
    .rd_addr_i (pc_q),
    .rd_data_o (rd_data_s)
  );

  assign load_ready_s = (state_q == ST_IDLE) && (wr_cnt_q < CNT_FULL) && !start && !clear;
  assign wr_en_s      = load_valid && load_ready_s;
  // The end check compares against wr_cnt so pc never has to reach DEPTH.
  assign last_s       = (({1'b0, pc_q} + (AW+1)'(1)) == wr_cnt_q);

  // Next-state, counter, pc, error and field-latch logic.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    pc_d     = pc_q;
    err_d    = err_q;
    word_d   = word_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          wr_cnt_d = '0;
          err_d    = 1'b0;
        end else if (start) begin
          if (wr_cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = '0;
            state_d = ST_FETCH;
          end
        end else if (wr_en_s) begin
          wr_cnt_d = wr_cnt_q + (AW+1)'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (rd_data_s == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (rd_data_s[OPC_LSB +: 7] != OPC_RTYPE) begin
          err_d = 1'b1;
          if (last_s) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_FETCH;
          end
        end else begin
          word_d  = rd_data_s;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
          if (last_s) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      pc_q     <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  assign load_ready  = load_ready_s;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_ISSUE);
  assign done        = (state_q == ST_DONE);
  assign issue_valid = (state_q == ST_ISSUE);
  assign err         = err_q;
  assign pc          = pc_q;
  assign opcode      = word_q[OPC_LSB +: 7];
  assign rd          = word_q[RD_LSB  +: 5];
  assign funct3      = word_q[F3_LSB  +: 3];
  assign rs1         = word_q[RS1_LSB +: 5];
  assign rs2         = word_q[RS2_LSB +: 5];
  assign funct7      = word_q[F7_LSB  +: 7];

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed scenarios plus randomized
// programs checked against a program-level reference model.
module tb_instr_seq_ctrl;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [31:0]   load_data = 32'h0;
  logic          load_ready;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err, issue_valid;
  logic          issue_ready = 1'b0;
  logic [6:0]    opcode, funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [AW-1:0] pc;

  instr_seq_ctrl #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .clear(clear), .start(start), .busy(busy),
    .done(done), .err(err), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .pc(pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] prog[$];
  logic [31:0] exp_w[$];
  int          exp_pc[$];
  logic        exp_err;
  int          exp_final_pc;
  logic [31:0] obs_w[$];
  int          obs_pc[$];
  int          done_cnt;
  bit          timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cur_word();
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

  // Program-level model: walk the words, stop on halt, skip non-R-type.
  task automatic model_run();
    exp_w.delete();
    exp_pc.delete();
    exp_err = 1'b0;
    exp_final_pc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      logic [31:0] w;
      w = prog[i];
      exp_final_pc = i;
      if (w == 32'h0) break;
      if (w[6:0] != 7'h33) begin
        exp_err = 1'b1;
      end else begin
        exp_w.push_back(w);
        exp_pc.push_back(i);
      end
    end
  endtask

  task automatic load_prog();
    bit acc;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    foreach (prog[i]) begin
      acc = 1'b0;
      load_valid = 1'b1;
      load_data  = prog[i];
      for (int t = 0; t < 10 && !acc; t++) begin
        #1;
        acc = load_ready;
        tick();
      end
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL load_accept: word %0d not accepted, required accept", i);
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic run_prog(input int ready_pct);
    obs_w.delete();
    obs_pc.delete();
    done_cnt  = 0;
    timed_out = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      issue_ready = ($urandom_range(99) < ready_pct);
      if (issue_valid && issue_ready) begin
        obs_w.push_back(cur_word());
        obs_pc.push_back(int'(pc));
      end
      if (done) begin
        done_cnt++;
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, err, issue_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000", {busy, done, err, issue_valid});
    end
    checks++;
    if (pc !== 5'd0) begin
      failures++;
      $display("FAIL reset_pc: got %0d required 0", pc);
    end
    checks++;
    if (cur_word() !== 32'h0) begin
      failures++;
      $display("FAIL reset_fields: got %h required 0", cur_word());
    end
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_load_ready: got %b required 1", load_ready);
    end
  endtask

  task automatic test_single_issue();
    prog = '{32'h002081B3};
    load_prog();
    issue_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid: got %b at T+2 required 0", issue_valid);
    end
    tick();
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: issue_valid %b at T+3 required 1", issue_valid);
    end
    checks++;
    if ({opcode, rd, funct3, rs1, rs2, funct7} !== {7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00}) begin
      failures++;
      $display("FAIL single_fields: op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h required 33/3/0/1/2/00",
               opcode, rd, funct3, rs1, rs2, funct7);
    end
    tick();
    checks++;
    if ({done, busy, err} !== 3'b100) begin
      failures++;
      $display("FAIL single_done: done,busy,err=%b required 100", {done, busy, err});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: done=%b one cycle later, required 0", done);
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] cap;
    bit seen;
    int dn;
    prog = '{32'h002081B3, 32'h407302B3};
    load_prog();
    issue_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (issue_valid) seen = 1'b1; else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stall_first_issue: issue_valid never seen, required 1");
    end
    cap = cur_word();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (!issue_valid || cur_word() !== 32'h002081B3 || cur_word() !== cap) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d valid=%b word=%h required 1/002081B3", k, issue_valid, cur_word());
      end
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (issue_valid) seen = 1'b1; else tick();
    end
    checks++;
    if (!seen || {rd, rs1, rs2, funct7} !== {5'd5, 5'd6, 5'd7, 7'h20} || pc !== 5'd1) begin
      failures++;
      $display("FAIL stall_second: seen=%b rd=%0d rs1=%0d rs2=%0d f7=%h pc=%0d required 5/6/7/20 pc 1",
               seen, rd, rs1, rs2, funct7, pc);
    end
    issue_ready = 1'b1;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) dn++;
    end
    issue_ready = 1'b0;
    checks++;
    if (dn != 1) begin
      failures++;
      $display("FAIL stall_done_count: got %0d required 1", dn);
    end
  endtask

  task automatic test_halt();
    prog = '{32'h002081B3, 32'h00000000, 32'h407302B3};
    load_prog();
    run_prog(60);
    checks++;
    if (timed_out || done_cnt != 1 || obs_w.size() != 1) begin
      failures++;
      $display("FAIL halt_run: timeout=%b done=%0d issues=%0d required 0/1/1", timed_out, done_cnt, obs_w.size());
    end else begin
      checks++;
      if (obs_w[0] !== 32'h002081B3 || pc !== 5'd1) begin
        failures++;
        $display("FAIL halt_issue: word=%h pc=%0d required 002081B3 pc 1", obs_w[0], pc);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w0;
    prog = '{32'h00100093, 32'h002081B3};
    load_prog();
    run_prog(50);
    checks++;
    if (err !== 1'b1 || obs_w.size() != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL illegal_run: err=%b issues=%0d done=%0d required 1/1/1", err, obs_w.size(), done_cnt);
    end else begin
      w0 = obs_w[0];
      checks++;
      if (w0[11:7] !== 5'd3 || obs_pc[0] != 1) begin
        failures++;
        $display("FAIL illegal_issue: rd=%0d pc=%0d required rd 3 pc 1", w0[11:7], obs_pc[0]);
      end
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_sticky: err=%b required 1", err);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear: err=%b required 0", err);
    end
  endtask

  task automatic test_full_and_empty();
    int acc_cnt;
    int bad;
    int iv;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    prog.delete();
    acc_cnt = 0;
    load_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      load_data = {$urandom_range(32'h1FF_FFFF), 7'h33};
      #1;
      if (load_ready) begin
        acc_cnt++;
        prog.push_back(load_data);
      end
      tick();
    end
    #1;
    checks++;
    if (acc_cnt != DEPTH || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_accepts: accepted=%0d ready=%b required 32/0", acc_cnt, load_ready);
    end
    load_valid = 1'b0;
    model_run();
    run_prog(70);
    bad = 0;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      if (obs_w[i] !== exp_w[i] || obs_pc[i] != exp_pc[i]) bad++;
    checks++;
    if (obs_w.size() != DEPTH || bad != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL full_issues: issues=%0d bad=%0d done=%0d required 32/0/1", obs_w.size(), bad, done_cnt);
    end
    checks++;
    if (pc !== 5'd31) begin
      failures++;
      $display("FAIL full_final_pc: got %0d required 31", pc);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL empty_done: done=%b at T+1 required 1", done);
    end
    iv = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (issue_valid) iv++;
    end
    checks++;
    if (iv != 0) begin
      failures++;
      $display("FAIL empty_issues: got %0d required 0", iv);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int dn;
    prog = '{32'h00100093, 32'h002081B3, 32'h407302B3};
    load_prog();
    issue_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (issue_valid && pc == 5'd2) seen = 1'b1; else tick();
    end
    checks++;
    if (!seen || err !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reach: seen=%b err=%b required 1/1", seen, err);
    end
    rst = 1'b1;
    issue_ready = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, err, issue_valid} !== 4'b0000 || pc !== 5'd0 || cur_word() !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: flags=%b pc=%0d word=%h required 0", {busy, done, err, issue_valid}, pc, cur_word());
    end
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d pulses required 0", dn);
    end
    run_prog(100);
    checks++;
    if (done_cnt != 1 || obs_w.size() != 0 || timed_out) begin
      failures++;
      $display("FAIL midreset_restart: done=%0d issues=%0d timeout=%b required 1/0/0", done_cnt, obs_w.size(), timed_out);
    end
  endtask

  task automatic test_random();
    int n;
    int bad;
    int r;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 12);
      prog.delete();
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(99);
        if (r < 70) prog.push_back({$urandom_range(32'h1FF_FFFF), 7'h33});
        else if (r < 85) prog.push_back({$urandom_range(32'h1FF_FFFF), 7'h13});
        else prog.push_back(32'h0);
      end
      load_prog();
      model_run();
      for (int rep = 0; rep < 2; rep++) begin
        run_prog($urandom_range(20, 100));
        bad = 0;
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
          if (obs_w[i] !== exp_w[i] || obs_pc[i] != exp_pc[i]) bad++;
        checks++;
        if (timed_out || done_cnt != 1 || obs_w.size() != exp_w.size() || bad != 0) begin
          failures++;
          $display("FAIL random_issues: it=%0d rep=%0d timeout=%b done=%0d issues=%0d/%0d bad=%0d",
                   it, rep, timed_out, done_cnt, obs_w.size(), exp_w.size(), bad);
        end
        checks++;
        if (err !== exp_err || int'(pc) != exp_final_pc) begin
          failures++;
          $display("FAIL random_state: it=%0d err=%b pc=%0d required err=%b pc=%0d",
                   it, err, pc, exp_err, exp_final_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_stall();
    test_halt();
    test_illegal();
    test_full_and_empty();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
